// File: rtl/mem_wb_lsu.sv
// Memory-access stage and MEM/WB pipeline register with a req/ack data-memory port.
// Optional MEM_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYCLES without ack (reported on misalign_o).
module mem_wb_lsu #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] instr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        misalign_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] WBData_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, next_state;
  logic        mem_op, misaligned, timeout, err_q;
  logic [2:0]  funct3, f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_ext, load_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign funct3  = instr_i[14:12];
  assign stall_o = mem_op & (state != S_DONE);

  // Lane placement: narrow store data is replicated so any byte/half lane sees it.
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = RDData_i;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResult_i[1:0];
        wdata_c = {4{RDData_i[7:0]}};
      end
      2'b01: begin
        misaligned = ALUResult_i[0];
        be_c       = ALUResult_i[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{RDData_i[15:0]}};
      end
      default: misaligned = |ALUResult_i[1:0];
    endcase
  end

  always_comb begin
    byte_sel = dmem_rdata_i[7:0];
    case (off_q)
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      2'd3:    byte_sel = dmem_rdata_i[31:24];
      default: byte_sel = dmem_rdata_i[7:0];
    endcase
    half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dmem_rdata_i;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i)
      cnt <= '0;
    else if (state == S_WAIT && !dmem_ack_i)
      cnt <= cnt + CNT_W'(1);
    else
      cnt <= '0;
  end

  assign timeout = (state == S_WAIT) && !dmem_ack_i && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > CNT_W);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (mem_op) next_state = misaligned ? S_DONE : S_WAIT;
      S_WAIT:  if (dmem_ack_i || timeout) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // While stalled the MEM/WB register holds its fields and only RegWrite_o is forced to a bubble.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= '0;
      misalign_o   <= 1'b0;
      pc_o         <= '0;
      instr_o      <= '0;
      VALUResult_o <= '0;
      ALUResult_o  <= '0;
      WBData_o     <= '0;
      RDaddr_o     <= '0;
      RegWrite_o   <= 1'b0;
      err_q        <= 1'b0;
      load_q       <= '0;
      off_q        <= '0;
      f3_q         <= '0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!mem_op) begin
            pc_o         <= pc_i;
            instr_o      <= instr_i;
            VALUResult_o <= VALUResult_i;
            ALUResult_o  <= ALUResult_i;
            WBData_o     <= ALUResult_i;
            RDaddr_o     <= RDaddr_i;
            RegWrite_o   <= RegWrite_i;
          end else begin
            RegWrite_o <= 1'b0;
            err_q      <= misaligned;
            load_q     <= '0;
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= MemWrite_i;
              dmem_addr_o  <= {ALUResult_i[31:2], 2'b00};
              dmem_be_o    <= be_c;
              dmem_wdata_o <= wdata_c;
              off_q        <= ALUResult_i[1:0];
              f3_q         <= funct3;
            end
          end
        end
        S_WAIT: begin
          RegWrite_o <= 1'b0;
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            load_q     <= load_ext;
          end else if (timeout) begin
            dmem_req_o <= 1'b0;
            misalign_o <= 1'b1;
            err_q      <= 1'b1;
          end
        end
        S_DONE: begin
          pc_o         <= pc_i;
          instr_o      <= instr_i;
          VALUResult_o <= VALUResult_i;
          ALUResult_o  <= ALUResult_i;
          WBData_o     <= MemToReg_i ? load_q : ALUResult_i;
          RDaddr_o     <= RDaddr_i;
          RegWrite_o   <= RegWrite_i & ~MemWrite_i & ~err_q & (RDaddr_i != 5'd0);
          err_q        <= 1'b0;
        end
        default: RegWrite_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Self-checking bench for mem_wb_lsu: directed vectors plus randomized ops against a behavioural model.
module tb_mem_wb_lsu;

  logic        clk_i, start_i;
  logic [31:0] pc_i, ALUResult_i, VALUResult_i, RDData_i, instr_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic        stall_o, dmem_req_o, dmem_we_o, dmem_ack_i, misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] pc_o, instr_o, VALUResult_o, ALUResult_o, WBData_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o;

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_stall, obs_waits, obs_req_cycle;
  logic        obs_req, obs_we, obs_mis, obs_mis_after, obs_hung, obs_unstable;
  logic [31:0] obs_addr, obs_wdata, cur_pc;
  logic [3:0]  obs_be;

  mem_wb_lsu dut (
    .clk_i(clk_i), .start_i(start_i), .pc_i(pc_i), .ALUResult_i(ALUResult_i),
    .VALUResult_i(VALUResult_i), .RDData_i(RDData_i), .RDaddr_i(RDaddr_i), .instr_i(instr_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .misalign_o(misalign_o), .pc_o(pc_o), .instr_o(instr_o),
    .VALUResult_o(VALUResult_o), .ALUResult_o(ALUResult_o), .WBData_o(WBData_o),
    .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: access size, lanes and load extension from the ISA rules.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    int sz, off;
    sz  = size_of(f3);
    off = int'(addr % 4);
    be  = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = size_of(f3);
    v  = rd >> (8 * (addr % 4));
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic set_nop();
    pc_i = '0; instr_i = '0; ALUResult_i = '0; VALUResult_i = '0; RDData_i = '0; RDaddr_i = '0;
    RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
  endtask

  // Drives one EX/MEM op, plays the memory with the given ack delay, returns after the MEM/WB capture.
  task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] rd, input logic rw,
                       input logic [31:0] rdata, input int delay);
    logic [31:0] ins;
    int n, waited;
    ins = $urandom;
    ins[14:12] = f3;
    cur_pc = $urandom;
    pc_i = cur_pc; instr_i = ins; VALUResult_i = $urandom; ALUResult_i = addr; RDData_i = sdata;
    RDaddr_i = rd; RegWrite_i = rw;
    MemRead_i = (kind == 1); MemWrite_i = (kind == 2); MemToReg_i = (kind == 1);
    obs_req = 0; obs_unstable = 0; obs_req_cycle = -1; n = 0; waited = 0; dmem_ack_i = 0;
    #1;
    while (stall_o === 1'b1 && n < 300) begin
      n++;
      if (dmem_req_o === 1'b1) begin
        if (!obs_req) begin
          obs_req = 1; obs_req_cycle = n - 1;
          obs_addr = dmem_addr_o; obs_be = dmem_be_o; obs_we = dmem_we_o; obs_wdata = dmem_wdata_o;
        end else if ({dmem_addr_o, dmem_be_o, dmem_we_o, dmem_wdata_o} !==
                     {obs_addr, obs_be, obs_we, obs_wdata}) begin
          obs_unstable = 1;
        end
        if (waited == delay) begin
          dmem_ack_i = 1; dmem_rdata_i = rdata;
        end
        waited++;
      end
      @(posedge clk_i); #1;
      dmem_ack_i = 0; dmem_rdata_i = $urandom;
      #1;
    end
    obs_stall = n; obs_waits = waited; obs_hung = (n >= 300); obs_mis = misalign_o;
    @(posedge clk_i); #1;
    obs_mis_after = misalign_o;
    set_nop();
  endtask

  task automatic test_reset();
    start_i = 0; dmem_ack_i = 0; dmem_rdata_i = $urandom;
    set_nop();
    pc_i = $urandom; ALUResult_i = $urandom; RDaddr_i = 5'd9; RegWrite_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++; if (pc_o !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_pc: got %h want 0", pc_o); end
    n_cmp++; if (WBData_o !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_wb: got %h want 0", WBData_o); end
    n_cmp++; if (RegWrite_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rw: got %b want 0", RegWrite_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req: got %b want 0", dmem_req_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall_o); end
    n_cmp++; if ({misalign_o, RDaddr_o, dmem_addr_o} !== 38'd0) begin
      n_bad++; $display("[TB] FAIL reset_misc: got %h want 0", {misalign_o, RDaddr_o, dmem_addr_o});
    end
    set_nop();
    start_i = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    issue(0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h0, 0);
    n_cmp++; if (obs_stall !== 0) begin n_bad++; $display("[TB] FAIL alu_stall: got %0d want 0", obs_stall); end
    n_cmp++; if ({RDaddr_o, WBData_o, RegWrite_o} !== {5'd5, 32'h1234, 1'b1}) begin
      n_bad++; $display("[TB] FAIL alu_wb: got rd=%0d wb=%h rw=%b want rd=5 wb=1234 rw=1", RDaddr_o, WBData_o, RegWrite_o);
    end
    n_cmp++; if (pc_o !== cur_pc) begin n_bad++; $display("[TB] FAIL alu_pc: got %h want %h", pc_o, cur_pc); end

    issue(1, 3'b010, 32'h100, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF, 0);
    n_cmp++; if (obs_stall !== 2) begin n_bad++; $display("[TB] FAIL lw_stall: got %0d want 2", obs_stall); end
    n_cmp++; if ({obs_addr, obs_be, obs_we} !== {32'h100, 4'hF, 1'b0}) begin
      n_bad++; $display("[TB] FAIL lw_req: got addr=%h be=%h we=%b want 100 f 0", obs_addr, obs_be, obs_we);
    end
    n_cmp++; if ({WBData_o, RegWrite_o} !== {32'hDEADBEEF, 1'b1}) begin
      n_bad++; $display("[TB] FAIL lw_wb: got %h rw=%b want deadbeef rw=1", WBData_o, RegWrite_o);
    end

    issue(1, 3'b000, 32'h103, 32'h0, 5'd8, 1'b1, 32'h80FF_FFFF, 1);
    n_cmp++; if (WBData_o !== 32'hFFFFFF80) begin n_bad++; $display("[TB] FAIL lb_wb: got %h want ffffff80", WBData_o); end
    n_cmp++; if (obs_stall !== 3) begin n_bad++; $display("[TB] FAIL lb_stall: got %0d want 3", obs_stall); end
    issue(1, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1, 32'h80FF_FFFF, 0);
    n_cmp++; if (WBData_o !== 32'h00000080) begin n_bad++; $display("[TB] FAIL lbu_wb: got %h want 00000080", WBData_o); end

    issue(2, 3'b001, 32'h202, 32'h0000ABCD, 5'd3, 1'b1, 32'h0, 0);
    n_cmp++; if ({obs_we, obs_be, obs_wdata, obs_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200}) begin
      n_bad++; $display("[TB] FAIL sh_req: got we=%b be=%b wd=%h a=%h want 1 1100 abcdabcd 200", obs_we, obs_be, obs_wdata, obs_addr);
    end
    n_cmp++; if (RegWrite_o !== 1'b0) begin n_bad++; $display("[TB] FAIL sh_rw: got %b want 0", RegWrite_o); end

    issue(1, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0, 0);
    n_cmp++; if ({obs_req, obs_mis, obs_mis_after, RegWrite_o} !== 4'b0100) begin
      n_bad++; $display("[TB] FAIL misalign: got req=%b mis=%b after=%b rw=%b want 0 1 0 0", obs_req, obs_mis, obs_mis_after, RegWrite_o);
    end
    n_cmp++; if (obs_stall !== 1) begin n_bad++; $display("[TB] FAIL misalign_stall: got %0d want 1", obs_stall); end

    issue(1, 3'b010, 32'h40, 32'h0, 5'd0, 1'b1, 32'h1111_2222, 0);
    n_cmp++; if ({RegWrite_o, WBData_o} !== {1'b0, 32'h1111_2222}) begin
      n_bad++; $display("[TB] FAIL load_x0: got rw=%b wb=%h want 0 11112222", RegWrite_o, WBData_o);
    end
  endtask

  task automatic test_random();
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] addr, sd, rd_word, exp_wb;
    logic [4:0]  rd;
    logic        rw, mis, exp_rw;
    int          kind, sz, delay, exp_stall;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      sz = size_of(f3);
      addr = $urandom;
      if (kind != 0) begin
        addr[1:0] = 2'b00;
        if (sz > 1 && $urandom_range(0, 3) == 0) addr = addr + ((sz == 2) ? 32'd1 : 32'($urandom_range(1, 3)));
        else addr = addr + 32'($urandom_range(0, (4 / sz) - 1) * sz);
      end
      sd = $urandom; rd_word = $urandom; rd = 5'($urandom); rw = 1'($urandom);
      delay = $urandom_range(0, 3);
      mis = (kind != 0) && ((addr % sz) != 0);
      exp_stall = (kind == 0) ? 0 : (mis ? 1 : 2 + delay);
      exp_rw = (kind == 0) ? rw : ((kind == 2) ? 1'b0 : (rw && !mis && rd != 5'd0));
      exp_wb = (kind == 1) ? model_load(f3, addr, rd_word) : addr;
      issue(kind, f3, addr, sd, rd, rw, rd_word, delay);
      n_cmp++; if (obs_stall !== exp_stall) begin
        n_bad++; $display("[TB] FAIL rnd%0d_stall: got %0d want %0d", t, obs_stall, exp_stall);
      end
      n_cmp++; if ({RegWrite_o, RDaddr_o, pc_o} !== {exp_rw, rd, cur_pc}) begin
        n_bad++; $display("[TB] FAIL rnd%0d_wbctl: got rw=%b rd=%0d pc=%h want %b %0d %h", t, RegWrite_o, RDaddr_o, pc_o, exp_rw, rd, cur_pc);
      end
      if (!mis) begin
        n_cmp++; if (WBData_o !== exp_wb) begin
          n_bad++; $display("[TB] FAIL rnd%0d_wbdata: got %h want %h", t, WBData_o, exp_wb);
        end
      end
      if (kind != 0) begin
        n_cmp++; if ({obs_req, obs_mis} !== {!mis, mis}) begin
          n_bad++; $display("[TB] FAIL rnd%0d_reqmis: got req=%b mis=%b want %b %b", t, obs_req, obs_mis, !mis, mis);
        end
        if (!mis) begin
          n_cmp++; if ({obs_addr, obs_be, obs_we, obs_unstable, obs_req_cycle} !==
                       {addr & 32'hFFFF_FFFC, model_be(f3, addr), (kind == 2), 1'b0, 1}) begin
            n_bad++; $display("[TB] FAIL rnd%0d_req: got a=%h be=%b we=%b unst=%b cyc=%0d want %h %b %b 0 1", t,
                              obs_addr, obs_be, obs_we, obs_unstable, obs_req_cycle, addr & 32'hFFFF_FFFC,
                              model_be(f3, addr), (kind == 2));
          end
          if (kind == 2) begin
            n_cmp++; if (obs_wdata !== model_wdata(f3, sd)) begin
              n_bad++; $display("[TB] FAIL rnd%0d_wdata: got %h want %h", t, obs_wdata, model_wdata(f3, sd));
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      issue(1, 3'b010, 32'h1000 + 32'(4 * i), 32'h0, 5'd10, 1'b1, w, 0);
      n_cmp++; if ({obs_req_cycle, obs_stall} !== {1, 2}) begin
        n_bad++; $display("[TB] FAIL b2b%0d_timing: got reqcyc=%0d stall=%0d want 1 2", i, obs_req_cycle, obs_stall);
      end
      n_cmp++; if (WBData_o !== w) begin n_bad++; $display("[TB] FAIL b2b%0d_wb: got %h want %h", i, WBData_o, w); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    set_nop();
    pc_i = 32'h44; ALUResult_i = 32'h300; RDaddr_i = 5'd6; RegWrite_i = 1; MemRead_i = 1; MemToReg_i = 1;
    instr_i = 32'h0000_2003;
    n = 0;
    @(posedge clk_i); #1;
    while (dmem_req_o !== 1'b1 && n < 10) begin @(posedge clk_i); #1; n++; end
    n_cmp++; if (dmem_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_wait_req: got %b want 1", dmem_req_o); end
    #2 start_i = 0;
    #1;
    n_cmp++; if ({dmem_req_o, RegWrite_o, WBData_o, pc_o, dmem_addr_o} !== '0) begin
      n_bad++; $display("[TB] FAIL rst_wait_clear: got req=%b rw=%b wb=%h pc=%h a=%h want all 0", dmem_req_o, RegWrite_o, WBData_o, pc_o, dmem_addr_o);
    end
    set_nop();
    @(posedge clk_i); #1;
    start_i = 1;
    dmem_ack_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    dmem_ack_i = 0;
    @(posedge clk_i); #1;
    n_cmp++; if ({dmem_req_o, RegWrite_o, misalign_o, stall_o, WBData_o} !== '0) begin
      n_bad++; $display("[TB] FAIL rst_late_ack: got req=%b rw=%b mis=%b st=%b wb=%h want all 0", dmem_req_o, RegWrite_o, misalign_o, stall_o, WBData_o);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    issue(1, 3'b010, 32'h500, 32'h0, 5'd12, 1'b1, 32'h0, 1000);
    n_cmp++; if ({obs_waits, obs_stall} !== {64, 65}) begin
      n_bad++; $display("[TB] FAIL timeout_len: got waits=%0d stall=%0d want 64 65", obs_waits, obs_stall);
    end
    n_cmp++; if ({obs_mis, RegWrite_o, dmem_req_o} !== 3'b100) begin
      n_bad++; $display("[TB] FAIL timeout_err: got mis=%b rw=%b req=%b want 1 0 0", obs_mis, RegWrite_o, dmem_req_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_lsu.md
Name: mem_wb_lsu

Overview:
Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its pc, ALU result, vector ALU result, store data, destination and control outputs. Loads and stores go through a req/ack data-memory handshake. While an access is in flight it drives Stall back to EX/MEM. Results are registered toward writeback.

Parameters:
TIMEOUT_CYCLES, 64, max WAIT-state cycles before abort (used only with MEM_TIMEOUT_EN)
CNT_W, 7, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  input  1  clock, all state on rising edge
start_i  input  1  asynchronous active-low reset
pc_i  input  32  pc from EX/MEM
ALUResult_i  input  32  effective address / ALU result
VALUResult_i  input  32  vector ALU result, passthrough
RDData_i  input  32  store data
RDaddr_i  input  5  destination register
instr_i  input  32  instruction; funct3 = instr_i[14:12]
RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  input  1 each  control from EX/MEM
stall_o  output  1  to EX/MEM Stall; holds upstream
dmem_req_o  output  1  memory request, registered
dmem_we_o  output  1  1 = store
dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  output  32  lane-shifted store data
dmem_be_o  output  4  byte enables
dmem_ack_i  input  1  single-cycle completion pulse
dmem_rdata_i  input  32  read word, valid with ack
misalign_o  output  1  one-cycle pulse on misaligned access
pc_o, instr_o, VALUResult_o, ALUResult_o  output  32 each  MEM/WB registered copies
WBData_o  output  32  MemToReg ? extended load data : ALUResult
RDaddr_o  output  5  registered destination
RegWrite_o  output  1  registered write enable

Behaviour:
- Reset (start_i low, async): all outputs 0; FSM to IDLE; counter 0. Reset during WAIT drops dmem_req_o immediately; the access is abandoned and a late ack is ignored.
- Definition: mem_op = MemRead_i | MemWrite_i.
- FSM states:
  - IDLE:
    - No mem_op: MEM/WB captures inputs every edge; stall_o = 0.
    - mem_op and aligned: register dmem_req_o=1, addr, we, be, wdata; go WAIT.
    - mem_op and misaligned (half with addr[0]=1, word with addr[1:0]!=0): no request; misalign_o pulses; go DONE with write suppressed.
  - WAIT: hold req/addr/we/be/wdata stable until dmem_ack_i. On ack: req<=0, latch extended rdata, go DONE. Ack seen in IDLE or DONE is ignored.
  - DONE: stall_o = 0 for exactly this cycle. MEM/WB captures inputs plus the latched load data. Go IDLE.
- stall_o (combinational) = mem_op & (state != DONE).
- While stalled, the MEM/WB register captures a bubble (RegWrite_o=0) and the other fields hold.
- Best-case load/store: 3 cycles (IDLE, WAIT with ack, DONE). Each extra ack-wait cycle adds one.
- Back-to-back mem ops: DONE returns to IDLE, and the next op starts a new request on the following cycle.
- Store lanes by funct3:
  - sb: be = 1<<addr[1:0]; byte replicated in all lanes.
  - sh: be = addr[1] ? 1100 : 0011; half replicated.
  - sw: be = 1111.
- Load extraction by funct3, selecting byte/half by addr[1:0]:
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: full word.
- Stores always complete with RegWrite_o=0 regardless of RegWrite_i.
- Loads to RDaddr=0 complete normally; RegWrite_o=0.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without ack: drop req, pulse misalign_o (shared error line), go DONE with RegWrite_o=0.
- Undefined: no counter; WAIT persists indefinitely until ack.

Test Plan:
- ALU op, RegWrite_i=1, RDaddr_i=5, ALUResult_i=0x1234 → next edge RDaddr_o=5, WBData_o=0x1234, RegWrite_o=1; stall_o never high.
- lw addr 0x100, ack one cycle after req, rdata 0xDEADBEEF → stall_o high 2 cycles; dmem_addr_o=0x100, be=1111; DONE yields WBData_o=0xDEADBEEF, RegWrite_o=1.
- lb addr 0x103, rdata 0x80FF_FFFF → WBData_o=0xFFFFFF80. lbu same → 0x00000080.
- sh addr 0x202, RDData_i=0x0000ABCD → dmem_we_o=1, be=1100, wdata=0xABCDABCD; RegWrite_o=0.
- lw addr 0x101 → no dmem_req_o, misalign_o pulse, RegWrite_o=0, stall released after 1 cycle.
- Reset asserted mid-WAIT, then ack arrives → dmem_req_o=0 immediately, all outputs 0, ack ignored. With MEM_TIMEOUT_EN and no ack: req drops after 64 WAIT cycles, error pulse.
